// File: rtl/fb_pkg.sv
// Shared screen geometry, coordinate widths and scheduler state encoding.
package fb_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;

    typedef enum logic [1:0] {
        ARB        = 2'd0,
        CLEAR_WAIT = 2'd1,
        CLEAR      = 2'd2
    } fb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: searches upward from the last-granted index + 1
// (wrapping) and returns a one-hot grant, or zero when nobody requests.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // first requester at or after last+1 wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = PTR_W'((int'(last) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Framebuffer write scheduler: round-robin arbitration of pixel-draw
// clients onto one registered write port, plus a frame-aligned full-screen
// clear sweep that pre-empts the clients.
module fb_write_scheduler #(
    parameter int NUM_REQ  = 2,
    parameter int SCREEN_W = fb_pkg::SCREEN_W,
    parameter int SCREEN_H = fb_pkg::SCREEN_H
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            frame_start,
    input  logic                            clear_req,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*fb_pkg::X_W-1:0]  req_x,
    input  logic [NUM_REQ*fb_pkg::Y_W-1:0]  req_y,
    input  logic [NUM_REQ-1:0]              req_color,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            clear_busy,
    output logic [fb_pkg::X_W-1:0]          x,
    output logic [fb_pkg::Y_W-1:0]          y,
    output logic                            pixel_color,
    output logic                            pixel_write
);

    import fb_pkg::*;

    localparam int               PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [X_W-1:0]   X_LIM   = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0]   Y_LIM   = Y_W'(SCREEN_H);
    localparam logic [X_W-1:0]   X_LAST  = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(SCREEN_H - 1);
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

    fb_state_t          state, state_nxt;
    logic [PTR_W-1:0]   last_gnt, gnt_idx;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [X_W-1:0]     cx, sel_x;
    logic [Y_W-1:0]     cy, sel_y;
    logic               sel_c;
    logic               sweep_done;
    logic               in_range;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req   (req),
        .last  (last_gnt),
        .grant (arb_gnt)
    );

    assign sweep_done = (cx == X_LAST) && (cy == Y_LAST);
    assign clear_busy = (state != ARB);
    assign in_range   = (sel_x < X_LIM) && (sel_y < Y_LIM);

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ARB;
        else          state <= state_nxt;
    end

    // next state; clients only see grants in ARB and lose to a clear request.
    // A clear arriving with frame_start lands in CLEAR_WAIT, which only
    // looks at frame_start from the following cycle, so it waits a frame.
    always_comb begin
        state_nxt = state;
        gnt       = '0;
        case (state)
            ARB: begin
                if (clear_req) state_nxt = CLEAR_WAIT;
                else           gnt       = arb_gnt;
            end
            CLEAR_WAIT: if (frame_start) state_nxt = CLEAR;
            CLEAR:      if (sweep_done)  state_nxt = ARB;
            default:    state_nxt = ARB;
        endcase
        if (!reset_n) gnt = '0;
    end

    // route the granted client's pixel
    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_c   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_x   = req_x[i*X_W +: X_W];
                sel_y   = req_y[i*Y_W +: Y_W];
                sel_c   = req_color[i];
                gnt_idx = PTR_W'(i);
            end
        end
    end

    // round-robin pointer, only moved by real grants (clears leave it alone)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  last_gnt <= PTR_RST;
        else if (|gnt) last_gnt <= gnt_idx;
    end

    // raster sweep counters; they wrap to 0 after the final pixel so the
    // next clear starts at the origin
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cx <= '0;
            cy <= '0;
        end else if (state == CLEAR) begin
            if (cx == X_LAST) begin
                cx <= '0;
                cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

    // registered write port; off-screen client pixels are consumed silently
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x           <= '0;
            y           <= '0;
            pixel_color <= 1'b0;
            pixel_write <= 1'b0;
        end else begin
            pixel_write <= 1'b0;
            if (state == CLEAR) begin
                x           <= cx;
                y           <= cy;
                pixel_color <= 1'b0;
                pixel_write <= 1'b1;
            end else if ((|gnt) && in_range) begin
                x           <= sel_x;
                y           <= sel_y;
                pixel_color <= sel_c;
                pixel_write <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler: directed vector table, randomized client
// traffic against a round-robin reference model, clear sweeps and reset abort.
module tb_fb_write_scheduler;

    localparam int N = 2;
    localparam int W = 640;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        clear_req = 1'b0;
    logic [1:0]  req = '0;
    logic [19:0] req_x = '0;
    logic [17:0] req_y = '0;
    logic [1:0]  req_color = '0;
    logic [1:0]  gnt;
    logic        clear_busy;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        pixel_color;
    logic        pixel_write;

    int errors = 0;
    int checks = 0;
    int last_g = N - 1;

    always #5 clk = ~clk;

    fb_write_scheduler #(
        .NUM_REQ  (N),
        .SCREEN_W (W),
        .SCREEN_H (H)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .clear_req   (clear_req),
        .req         (req),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_color   (req_color),
        .gnt         (gnt),
        .clear_busy  (clear_busy),
        .x           (x),
        .y           (y),
        .pixel_color (pixel_color),
        .pixel_write (pixel_write)
    );

    typedef struct {
        logic [1:0] r;
        logic [9:0] x0; logic [8:0] y0; logic c0;
        logic [9:0] x1; logic [8:0] y1; logic c1;
        logic [1:0] eg;
        logic       ew;
        logic [9:0] ex; logic [8:0] ey; logic ec;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] r,
                         input logic [9:0] x0, input logic [8:0] y0, input logic c0,
                         input logic [9:0] x1, input logic [8:0] y1, input logic c1);
        req       = r;
        req_x     = {x1, x0};
        req_y     = {y1, y0};
        req_color = {c1, c0};
    endtask

    // reference round-robin: first requester scanning from last+1 upward
    function automatic logic [1:0] rr_expect(input logic [1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return 2'(1 << ((last + k) % N));
        end
        return 2'b00;
    endfunction

    function automatic int gidx(input logic [1:0] g);
        return g[1] ? 1 : 0;
    endfunction

    logic [1:0] pend;
    logic [9:0] px[N];
    logic [8:0] py[N];
    logic [1:0] pc;
    logic       exp_w;
    logic [9:0] exp_x;
    logic [8:0] exp_y;
    logic       exp_c;
    logic [1:0] g;
    int         n, done, found, bad_order, bad_busy, bad_gnt, bad_idle;
    logic [9:0] first_x;
    logic [8:0] first_y;

    initial begin
        vt[0]  = '{2'b01, 10'd5,   9'd7, 1'b1, 10'd0,  9'd0, 1'b0, 2'b01, 1'b0, 10'd0,   9'd0, 1'b0};
        vt[1]  = '{2'b00, 10'd0,   9'd0, 1'b0, 10'd0,  9'd0, 1'b0, 2'b00, 1'b1, 10'd5,   9'd7, 1'b1};
        vt[2]  = '{2'b10, 10'd0,   9'd0, 1'b0, 10'd20, 9'd2, 1'b1, 2'b10, 1'b0, 10'd0,   9'd0, 1'b0};
        vt[3]  = '{2'b11, 10'd10,  9'd1, 1'b0, 10'd21, 9'd2, 1'b1, 2'b01, 1'b1, 10'd20,  9'd2, 1'b1};
        vt[4]  = '{2'b11, 10'd11,  9'd1, 1'b0, 10'd21, 9'd2, 1'b1, 2'b10, 1'b1, 10'd10,  9'd1, 1'b0};
        vt[5]  = '{2'b11, 10'd11,  9'd1, 1'b0, 10'd22, 9'd2, 1'b1, 2'b01, 1'b1, 10'd21,  9'd2, 1'b1};
        vt[6]  = '{2'b11, 10'd12,  9'd1, 1'b0, 10'd22, 9'd2, 1'b1, 2'b10, 1'b1, 10'd11,  9'd1, 1'b0};
        vt[7]  = '{2'b01, 10'd640, 9'd0, 1'b1, 10'd0,  9'd0, 1'b0, 2'b01, 1'b1, 10'd22,  9'd2, 1'b1};
        vt[8]  = '{2'b10, 10'd0,   9'd0, 1'b0, 10'd3,  9'd8, 1'b1, 2'b10, 1'b0, 10'd0,   9'd0, 1'b0};
        vt[9]  = '{2'b00, 10'd0,   9'd0, 1'b0, 10'd0,  9'd0, 1'b0, 2'b00, 1'b0, 10'd0,   9'd0, 1'b0};
        vt[10] = '{2'b01, 10'd639, 9'd7, 1'b0, 10'd0,  9'd0, 1'b0, 2'b01, 1'b0, 10'd0,   9'd0, 1'b0};
        vt[11] = '{2'b00, 10'd0,   9'd0, 1'b0, 10'd0,  9'd0, 1'b0, 2'b00, 1'b1, 10'd639, 9'd7, 1'b0};

        // reset state, with requests already pending
        drive(2'b11, 10'd1, 9'd1, 1'b1, 10'd2, 9'd2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_xy", {x, y, pixel_color}, 0);
        chk("rst_wr", pixel_write, 0);
        drive(2'b00, 10'd0, 9'd0, 1'b0, 10'd0, 9'd0, 1'b0);
        reset_n = 1'b1;

        // directed table
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            drive(vt[i].r, vt[i].x0, vt[i].y0, vt[i].c0, vt[i].x1, vt[i].y1, vt[i].c1);
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), gnt, vt[i].eg);
            chk($sformatf("vec%0d_wr", i), pixel_write, vt[i].ew);
            chk($sformatf("vec%0d_busy", i), clear_busy, 0);
            if (vt[i].ew) chk($sformatf("vec%0d_pix", i), {x, y, pixel_color}, {vt[i].ex, vt[i].ey, vt[i].ec});
        end
        last_g = 0;

        // randomized clients holding their pixel until granted
        pend  = '0;
        pc    = '0;
        exp_w = 1'b0;
        exp_x = '0; exp_y = '0; exp_c = 1'b0;
        for (int i = 0; i < N; i++) begin px[i] = '0; py[i] = '0; end
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) != 0) begin
                    pend[i] = 1'b1;
                    px[i]   = ($urandom_range(0, 7) == 0) ? 10'(W + $urandom_range(0, 50))
                                                          : 10'($urandom_range(0, W - 1));
                    py[i]   = 9'($urandom_range(0, H));
                    pc[i]   = 1'($urandom_range(0, 1));
                end
            end
            drive(pend, px[0], py[0], pc[0], px[1], py[1], pc[1]);
            @(negedge clk);
            g = rr_expect(pend, last_g);
            chk("rand_gnt", gnt, g);
            chk("rand_wr", pixel_write, exp_w);
            if (exp_w) chk("rand_pix", {x, y, pixel_color}, {exp_x, exp_y, exp_c});
            exp_w = 1'b0;
            if (g != 2'b00) begin
                last_g = gidx(g);
                pend[last_g] = 1'b0;
                exp_w = (int'(px[last_g]) < W) && (int'(py[last_g]) < H);
                exp_x = px[last_g];
                exp_y = py[last_g];
                exp_c = pc[last_g];
            end
        end

        // clear request beats simultaneous client requests
        @(posedge clk); #1;
        drive(2'b11, 10'd1, 9'd1, 1'b1, 10'd2, 9'd2, 1'b1);
        clear_req = 1'b1;
        @(negedge clk);
        chk("clr_gnt_same", gnt, 0);
        chk("clr_busy_same", clear_busy, 0);
        @(posedge clk); #1;
        clear_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("clr_wait_busy", clear_busy, 1);
            chk("clr_wait_gnt", gnt, 0);
            chk("clr_wait_wr", pixel_write, 0);
            @(posedge clk); #1;
        end
        frame_start = 1'b1;
        @(negedge clk);
        chk("clr_fs_busy", clear_busy, 1);
        @(posedge clk); #1;
        frame_start = 1'b0;

        // sweep: consecutive raster writes, colour 0, grants held off;
        // a stray clear_req mid-sweep must not be queued
        n = 0; done = 0; bad_order = 0; bad_busy = 0; bad_gnt = 0;
        first_x = '1; first_y = '1;
        for (int cyc = 0; cyc < W * H + 20; cyc++) begin
            @(negedge clk);
            if (pixel_write) begin
                if (n == 0) begin first_x = x; first_y = y; end
                if (x != 10'(n % W) || y != 9'(n / W) || pixel_color) bad_order++;
                n++;
            end else if (n > 0) begin
                bad_order++;
            end
            if (n == W * H) begin done = 1; break; end
            if (!clear_busy) bad_busy++;
            if (gnt != 2'b00) bad_gnt++;
            @(posedge clk); #1;
            clear_req = (cyc == 40);
        end
        clear_req = 1'b0;
        chk("clr_done", done, 1);
        chk("clr_count", n, W * H);
        chk("clr_first", {first_x, first_y}, 0);
        chk("clr_order", bad_order, 0);
        chk("clr_busy_during", bad_busy, 0);
        chk("clr_gnt_during", bad_gnt, 0);
        chk("clr_last", {x, y, pixel_color}, {10'(W - 1), 9'(H - 1), 1'b0});
        chk("clr_busy_fall", clear_busy, 0);
        g = rr_expect(2'b11, last_g);
        chk("clr_gnt_resume", gnt, g);
        last_g = gidx(g);

        // arbitration continues where it left off, no queued clear
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            g = rr_expect(2'b11, last_g);
            chk("post_clr_gnt", gnt, g);
            chk("post_clr_busy", clear_busy, 0);
            last_g = gidx(g);
        end

        // clear coincident with frame_start waits for the next frame_start
        @(posedge clk); #1;
        clear_req   = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        chk("coinc_gnt", gnt, 0);
        @(posedge clk); #1;
        clear_req   = 1'b0;
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("coinc_busy", clear_busy, 1);
            chk("coinc_wr", pixel_write, 0);
            chk("coinc_gnt_wait", gnt, 0);
            @(posedge clk); #1;
        end
        frame_start = 1'b1;

        // reset in the middle of the sweep
        found = 0;
        for (int cyc = 0; cyc < W * H + 20; cyc++) begin
            @(negedge clk);
            if (pixel_write && x == 10'd100 && y == 9'd3) begin found = 1; break; end
            @(posedge clk); #1;
            frame_start = 1'b0;
        end
        frame_start = 1'b0;
        chk("abort_reach", found, 1);
        reset_n = 1'b0;
        #1;
        chk("abort_pix", {x, y, pixel_color}, 0);
        chk("abort_wr", pixel_write, 0);
        chk("abort_busy", clear_busy, 0);
        chk("abort_gnt", gnt, 0);
        drive(2'b00, 10'd0, 9'd0, 1'b0, 10'd0, 9'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bad_idle = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pixel_write || clear_busy) bad_idle++;
        end
        chk("abort_no_resume", bad_idle, 0);
        @(posedge clk); #1;
        drive(2'b11, 10'd1, 9'd1, 1'b1, 10'd2, 9'd2, 1'b1);
        @(negedge clk);
        chk("abort_ptr_rst", gnt, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
